// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional even parity, one stop bit.
// All outputs are registered; a request is accepted whenever busy is low, including the done cycle.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [12:0] BAUD_LAST = 13'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [12:0] baud;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        parity_bit;
  logic        baud_wrap;

  assign baud_wrap = (baud == BAUD_LAST);

  // tx is loaded with the value of the bit being entered, so the line changes
  // exactly at each baud wrap rather than one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          busy    <= 1'b0;
          baud    <= '0;
          bit_idx <= '0;
          if (start) begin
            shift      <= data_in;
            parity_bit <= ^data_in;
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
          end
        end

        START: begin
          if (baud_wrap) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + 13'd1;
          end
        end

        DATA: begin
          if (baud_wrap) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx    <= parity_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + 13'd1;
          end
        end

        PARITY: begin
          if (baud_wrap) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + 13'd1;
          end
        end

        STOP: begin
          if (baud_wrap) begin
            baud  <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            baud <= baud + 13'd1;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
          baud  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three instances (8 clk/bit no parity, 8 clk/bit parity, 5208 clk/bit)
// checked against a frame model built from the byte, and a mid-bit sampling receiver for loopback.
module tb_uart_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b, start_c;
  logic [7:0] data_a, data_b, data_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int tests = 0;
  int fails = 0;

  localparam int NA = 8;
  localparam int NC = 5208;

  uart_transmitter #(.CLKS_PER_BIT(NA), .PARITY_EN(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data_in(data_a),
    .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_transmitter #(.CLKS_PER_BIT(NA), .PARITY_EN(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data_in(data_b),
    .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  uart_transmitter #(.CLKS_PER_BIT(NC), .PARITY_EN(0)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .data_in(data_c),
    .tx(tx_c), .busy(busy_c), .done(done_c)
  );

  task automatic set_in(input int inst, input logic s, input logic [7:0] d);
    case (inst)
      0: begin start_a = s; data_a = d; end
      1: begin start_b = s; data_b = d; end
      default: begin start_c = s; data_c = d; end
    endcase
  endtask

  function automatic logic [2:0] outs(input int inst);
    case (inst)
      0: outs = {tx_a, busy_a, done_a};
      1: outs = {tx_b, busy_b, done_b};
      default: outs = {tx_c, busy_c, done_c};
    endcase
  endfunction

  // Expected line levels of a frame, one entry per bit period; unused slots stay 1.
  function automatic logic [10:0] model(input logic [7:0] b, input int par);
    logic q[$];
    logic [10:0] r;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (par != 0) q.push_back(^b);
    q.push_back(1'b1);
    r = '1;
    foreach (q[i]) r[i] = q[i];
    return r;
  endfunction

  // Observes one frame starting with the acceptance at the next rising edge.
  // Records the line level per bit period and whether it held steady, busy/done activity,
  // and applies the optional mid-frame start pulse and next-frame data.
  task automatic run_frame(input int inst, input int n, input int par, input bit hold,
                           input logic [7:0] next_d, input int pulse_k, input logic [7:0] pulse_d,
                           output logic [10:0] bits, output bit stable, output int busy_cnt,
                           output int done_cnt, output int done_k, output logic done_tx);
    int len;
    int j;
    logic [2:0] o;
    len = (10 + par) * n;
    bits = '1;
    stable = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    done_k = -1;
    done_tx = 1'bx;
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      o = outs(inst);
      if (k <= len) begin
        j = (k - 1) / n;
        if ((k - 1) % n == 0) bits[j] = o[2];
        else if (o[2] !== bits[j]) stable = 1'b0;
      end else begin
        done_tx = o[2];
      end
      if (o[1] === 1'b1) busy_cnt++;
      if (o[0] === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == 1 && !hold) set_in(inst, 1'b0, 8'($urandom));
      if (k == pulse_k) set_in(inst, 1'b1, pulse_d);
      else if (k == pulse_k + 1) set_in(inst, 1'b0, 8'($urandom));
      if (k == len + 1 && hold) set_in(inst, 1'b1, next_d);
    end
  endtask

  task automatic test_reset();
    logic [2:0] o;
    rst = 1'b1;
    set_in(0, 1'b1, 8'h5A);
    set_in(1, 1'b1, 8'hC3);
    set_in(2, 1'b1, 8'h0F);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      o = outs(0);
      tests++;
      if (o !== 3'b100) begin
        fails++;
        $display("FAIL reset_hold cycle %0d: {tx,busy,done}=%b expected 100", c, o);
      end
      o = outs(1);
      tests++;
      if (o !== 3'b100) begin
        fails++;
        $display("FAIL reset_hold_par cycle %0d: {tx,busy,done}=%b expected 100", c, o);
      end
    end
    rst = 1'b0;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      o = outs(0);
      tests++;
      if (o !== 3'b100) begin
        fails++;
        $display("FAIL reset_release cycle %0d: {tx,busy,done}=%b expected 100", c, o);
      end
    end
  endtask

  task automatic check_frame(input string name, input int n, input int par,
                             input logic [7:0] b, input logic [10:0] bits, input bit stable,
                             input int busy_cnt, input int done_cnt, input int done_k,
                             input logic done_tx);
    logic [10:0] exp_bits;
    int len;
    exp_bits = model(b, par);
    len = (10 + par) * n;
    tests++;
    if (bits !== exp_bits) begin
      fails++;
      $display("FAIL %s bits: got %b expected %b (byte %h)", name, bits, exp_bits, b);
    end
    tests++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL %s bit_width: tx changed inside a bit period, stable=%b expected 1", name, stable);
    end
    tests++;
    if (busy_cnt != len) begin
      fails++;
      $display("FAIL %s busy_len: got %0d expected %0d", name, busy_cnt, len);
    end
    tests++;
    if (done_cnt != 1 || done_k != len + 1) begin
      fails++;
      $display("FAIL %s done: count %0d at %0d expected 1 at %0d", name, done_cnt, done_k, len + 1);
    end
    tests++;
    if (done_tx !== 1'b1) begin
      fails++;
      $display("FAIL %s done_tx: got %b expected 1", name, done_tx);
    end
  endtask

  task automatic test_basic();
    logic [10:0] bits; bit st; int bc, dc, dk; logic dt;
    set_in(0, 1'b1, 8'hA5);
    run_frame(0, NA, 0, 1'b0, 8'h00, -10, 8'h00, bits, st, bc, dc, dk, dt);
    tests++;
    if (bits[9:0] !== 10'b1101001010) begin
      fails++;
      $display("FAIL basic_A5_line: got %b expected 1101001010", bits[9:0]);
    end
    check_frame("basic_A5", NA, 0, 8'hA5, bits, st, bc, dc, dk, dt);
  endtask

  task automatic test_parity();
    logic [10:0] bits; bit st; int bc, dc, dk; logic dt;
    set_in(1, 1'b1, 8'hA5);
    run_frame(1, NA, 1, 1'b0, 8'h00, -10, 8'h00, bits, st, bc, dc, dk, dt);
    tests++;
    if (bits[9] !== 1'b0) begin
      fails++;
      $display("FAIL parity_A5: got %b expected 0", bits[9]);
    end
    check_frame("parity_A5", NA, 1, 8'hA5, bits, st, bc, dc, dk, dt);
    set_in(1, 1'b1, 8'h07);
    run_frame(1, NA, 1, 1'b0, 8'h00, -10, 8'h00, bits, st, bc, dc, dk, dt);
    tests++;
    if (bits[9] !== 1'b1) begin
      fails++;
      $display("FAIL parity_07: got %b expected 1", bits[9]);
    end
    check_frame("parity_07", NA, 1, 8'h07, bits, st, bc, dc, dk, dt);
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits; bit st; int bc, dc, dk; logic dt;
    set_in(0, 1'b1, 8'h00);
    run_frame(0, NA, 0, 1'b1, 8'hFF, -10, 8'h00, bits, st, bc, dc, dk, dt);
    check_frame("b2b_00", NA, 0, 8'h00, bits, st, bc, dc, dk, dt);
    run_frame(0, NA, 0, 1'b0, 8'h00, -10, 8'h00, bits, st, bc, dc, dk, dt);
    check_frame("b2b_FF", NA, 0, 8'hFF, bits, st, bc, dc, dk, dt);
  endtask

  task automatic test_busy_reject();
    logic [10:0] bits; bit st; int bc, dc, dk; logic dt;
    logic [2:0] o;
    int extra;
    set_in(0, 1'b1, 8'h81);
    run_frame(0, NA, 0, 1'b0, 8'h00, 30, 8'h3C, bits, st, bc, dc, dk, dt);
    check_frame("reject_81", NA, 0, 8'h81, bits, st, bc, dc, dk, dt);
    extra = 0;
    for (int c = 0; c < 3 * NA; c++) begin
      @(negedge clk);
      o = outs(0);
      if (o !== 3'b100) extra++;
    end
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL reject_no_queue: %0d non-idle cycles after frame expected 0", extra);
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] bits; bit st; int bc, dc, dk; logic dt;
    logic [2:0] o;
    int bad;
    set_in(0, 1'b1, 8'h55);
    for (int k = 1; k <= 4 * NA + 3; k++) begin
      @(negedge clk);
      if (k == 1) set_in(0, 1'b0, 8'h00);
    end
    rst = 1'b1;
    @(negedge clk);
    o = outs(0);
    tests++;
    if (o !== 3'b100) begin
      fails++;
      $display("FAIL midreset_next: {tx,busy,done}=%b expected 100", o);
    end
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 12 * NA; c++) begin
      @(negedge clk);
      o = outs(0);
      if (o !== 3'b100) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL midreset_abandon: %0d non-idle cycles expected 0", bad);
    end
    set_in(0, 1'b1, 8'h12);
    run_frame(0, NA, 0, 1'b0, 8'h00, -10, 8'h00, bits, st, bc, dc, dk, dt);
    check_frame("midreset_12", NA, 0, 8'h12, bits, st, bc, dc, dk, dt);
  endtask

  task automatic test_random();
    logic [10:0] bits; bit st; int bc, dc, dk; logic dt;
    logic [7:0] b;
    for (int inst = 0; inst < 2; inst++) begin
      for (int r = 0; r < 4; r++) begin
        b = 8'($urandom);
        set_in(inst, 1'b1, b);
        run_frame(inst, NA, inst, 1'b0, 8'h00, -10, 8'h00, bits, st, bc, dc, dk, dt);
        check_frame(inst == 0 ? "random_nopar" : "random_par", NA, inst, b, bits, st, bc, dc, dk, dt);
      end
    end
  endtask

  // Independent receiver: find the start edge, then sample each bit at its midpoint.
  task automatic test_loopback();
    logic [7:0] rx;
    logic sbit, pbit;
    bit seen_edge, seen_done;
    set_in(2, 1'b1, 8'h4B);
    @(negedge clk);
    set_in(2, 1'b0, 8'h00);
    seen_edge = 1'b0;
    for (int c = 0; c < 20 && !seen_edge; c++) begin
      if (tx_c === 1'b0) seen_edge = 1'b1;
      else @(negedge clk);
    end
    tests++;
    if (!seen_edge) begin
      fails++;
      $display("FAIL loop_start_edge: tx stayed %b expected 0 within 20 cycles", tx_c);
    end
    repeat (NC / 2) @(negedge clk);
    sbit = tx_c;
    rx = '0;
    for (int i = 0; i < 8; i++) begin
      repeat (NC) @(negedge clk);
      rx[i] = tx_c;
    end
    repeat (NC) @(negedge clk);
    pbit = tx_c;
    seen_done = 1'b0;
    for (int c = 0; c < NC && !seen_done; c++) begin
      @(negedge clk);
      if (done_c === 1'b1) seen_done = 1'b1;
    end
    tests++;
    if (sbit !== 1'b0 || rx !== 8'h4B || pbit !== 1'b1) begin
      fails++;
      $display("FAIL loop_data: start %b data %h stop %b expected 0 4b 1", sbit, rx, pbit);
    end
    tests++;
    if (!seen_done) begin
      fails++;
      $display("FAIL loop_done: done seen %b expected 1", seen_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_busy_reject();
    test_mid_reset();
    test_random();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
